dna_packetizer: RTL and testbench
=================================

# dna_packetizer

Consumes the 57-bit device DNA produced by the DNA reader and serialises it as a framed byte packet on an AXI4-Stream master, for transport to the host through the existing byte-stream path. After reset it waits a fixed settle interval that covers the reader's full shift-out, then latches the DNA once. On each `send` request it emits a 10-byte packet: header, 8 DNA bytes, XOR checksum.

## Interface
- `SETTLE_CYCLES`, default 4096: cycles from reset release to DNA latch.
  - Range 1..65535.
  - Must exceed the reader's 64×57 = 3648-cycle shift-out.
- `HEADER`, default 8'hD5: first byte of every packet.

Ports:
- `aclk` in 1: single clock.
- `aresetn` in 1: reset, synchronous, active-low.
- `dna_data` in 57: DNA value from the reader.
- `send` in 1: packet request, sampled every cycle.
- `m_axis_tdata` out 8: packet byte.
- `m_axis_tvalid` out 1: byte valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: high on the checksum byte.
- `dna_ready` out 1: DNA latched.
- `busy` out 1: packet in progress.

## Operation
- States: WAIT, IDLE, SEND.
- WAIT:
  - 16-bit counter starts at 0 and increments each cycle.
  - When the counter equals `SETTLE_CYCLES-1`: `dna_data` is latched into the internal 57-bit DNA register, the FSM goes to IDLE, and `dna_ready` is set.
  - `send` seen in WAIT sets a single `pending` flag. Multiple requests collapse into one.
- IDLE:
  - If `send` or `pending` is set: clear `pending`, load byte index 0, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - Packet bytes are indexed 0..9.
  - Byte 0 = `HEADER`.
  - Bytes 1..8 = {7'b0, DNA} split into bytes, LSB byte first.
  - Byte 9 = XOR of bytes 1..8.
  - The index advances only on a handshake (`tvalid & tready`).
  - The handshake on index 9 returns the FSM to IDLE.
  - `send` is ignored in SEND and does not set `pending`.
- The DNA register is written only in WAIT. Later changes on `dna_data` never affect packets.
- `dna_ready` stays 1 until reset.
- `busy` = 1 exactly while in SEND.

## Timing
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0.
  - `dna_ready`=0, `busy`=0.
  - `pending`=0, counter=0, DNA register=0.
  - State = WAIT.
- All outputs are registered; no combinational path from inputs to outputs.
- Let edge 1 be the first rising edge with `aresetn`=1.
  - Latch happens on edge `SETTLE_CYCLES`.
  - `dna_ready` reads 1 after that edge.
- `send`=1 sampled in IDLE on edge k:
  - After edge k: `tvalid`=1 with byte 0, and `busy`=1.
- With `tready` held 1, one byte per cycle. The packet occupies 10 consecutive cycles with `tlast` on the 10th.
- AXI rule: once `tvalid`=1, `tvalid`, `tdata` and `tlast` hold stable until the handshake.
- After the final handshake: `tvalid`=0, `tlast`=0, `busy`=0, state = IDLE.
- `send` held high continuously gives back-to-back packets separated by exactly one idle cycle with `tvalid`=0.
- Pending request: the first packet starts one cycle after entering IDLE, i.e. `tvalid`=1 after edge `SETTLE_CYCLES`+1.
- Reset asserted mid-packet:
  - Next edge returns all reset values.
  - The packet is abandoned (no `tlast`).
  - The settle interval restarts from 0.

## Test plan
- Settle and latch:
  - Stimulus: `SETTLE_CYCLES`=4096, `dna_data`=57'h0123456789ABCDE, no `send`.
  - Required: `dna_ready` rises after edge 4096 and not earlier; `tvalid` stays 0 throughout.
- Basic packet:
  - Stimulus: DNA as above, 1-cycle `send` in IDLE, `tready`=1.
  - Required bytes: D5, DE, BC, 9A, 78, 56, 34, 12, 00, F0.
  - `tlast` only on F0; `busy` high for exactly 10 cycles.
- Backpressure:
  - Stimulus: same packet, `tready` toggling 1,0,0,1,…
  - Required: identical byte sequence; `tdata`/`tlast` stable while `tvalid` & !`tready`.
- Early request and latch isolation:
  - Stimulus: three `send` pulses during WAIT; then change `dna_data` to all-ones after the latch.
  - Required: exactly one packet starts on edge 4097, carrying the latched value (checksum F0), not ones.
- Continuous send:
  - Stimulus: `send` held 1, `tready`=1.
  - Required: packets of 10 bytes each with one idle cycle between them.
  - A `send` pulse during SEND produces no extra packet.
- Reset mid-packet:
  - Stimulus: assert `aresetn`=0 for 1 cycle after byte 4 is accepted.
  - Required: all outputs 0 on the next edge; `dna_ready` re-rises only after a new 4096-cycle settle.

Source files
------------

// File: rtl/dna_packetizer.sv
`default_nettype none
// ============================================================================
//  Module   : dna_packetizer
//  Purpose  : Latches the 57-bit device DNA once, after a fixed settle
//             interval that covers the reader's shift-out, and emits it on
//             request as a 10-byte AXI4-Stream packet:
//             header, 8 DNA bytes (LSB byte first), XOR checksum of the DNA bytes.
//  Ports    : aclk           - single clock
//             aresetn        - synchronous active-low reset
//             dna_data[56:0] - DNA value from the reader
//             send           - packet request, sampled every cycle
//             m_axis_tdata   - packet byte (registered)
//             m_axis_tvalid  - byte valid (registered)
//             m_axis_tready  - downstream ready
//             m_axis_tlast   - high on the checksum byte (registered)
//             dna_ready      - DNA has been latched (sticky until reset)
//             busy           - packet in progress
//  Revision : 1.0 - initial release
// ============================================================================
module dna_packetizer #(
    parameter int          SETTLE_CYCLES = 4096,
    parameter logic [7:0]  HEADER        = 8'hD5
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [56:0] dna_data,
    input  logic        send,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        dna_ready,
    output logic        busy
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  LAST_IDX    = 4'd9;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] settle_cnt;
    logic        pending;
    logic [56:0] dna_reg;
    logic [3:0]  byte_idx;

    logic [63:0] padded;
    logic [7:0]  checksum;
    logic [3:0]  next_idx;
    logic [7:0]  next_byte;

    // Byte that follows the one currently presented; loaded on a handshake
    // so tdata stays a pure register output.
    always_comb begin
        padded   = {7'b0, dna_reg};
        checksum = 8'h00;
        for (int i = 0; i < 8; i++) begin
            checksum = checksum ^ padded[8*i +: 8];
        end
        next_idx = byte_idx + 4'd1;
        case (next_idx)
            4'd1:    next_byte = padded[7:0];
            4'd2:    next_byte = padded[15:8];
            4'd3:    next_byte = padded[23:16];
            4'd4:    next_byte = padded[31:24];
            4'd5:    next_byte = padded[39:32];
            4'd6:    next_byte = padded[47:40];
            4'd7:    next_byte = padded[55:48];
            4'd8:    next_byte = padded[63:56];
            default: next_byte = checksum;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= ST_WAIT;
            settle_cnt    <= 16'd0;
            pending       <= 1'b0;
            dna_reg       <= 57'd0;
            byte_idx      <= 4'd0;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            dna_ready     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    settle_cnt <= settle_cnt + 16'd1;
                    // Requests during settle collapse into one deferred packet.
                    if (send) begin
                        pending <= 1'b1;
                    end
                    if (settle_cnt == SETTLE_LAST) begin
                        dna_reg   <= dna_data;
                        dna_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (send || pending) begin
                        pending       <= 1'b0;
                        byte_idx      <= 4'd0;
                        m_axis_tdata  <= HEADER;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        busy          <= 1'b1;
                        state         <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (byte_idx == LAST_IDX) begin
                            m_axis_tdata  <= 8'h00;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            busy          <= 1'b0;
                            state         <= ST_IDLE;
                        end else begin
                            byte_idx     <= next_idx;
                            m_axis_tdata <= next_byte;
                            m_axis_tlast <= (next_idx == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= ST_WAIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dna_packetizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dna_packetizer
//  Purpose  : Directed self-checking bench for dna_packetizer: reset values,
//             settle/latch timing, basic packet, backpressure, continuous
//             send, deferred request with latch isolation, mid-packet reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dna_packetizer;

    localparam int SETTLE = 4096;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [56:0] dna_data;
    logic        send;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        dna_ready;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    // Hand-computed packet for DNA 57'h0123456789ABCDE.
    logic [7:0] exp_pkt [10] = '{8'hD5, 8'hDE, 8'hBC, 8'h9A, 8'h78,
                                 8'h56, 8'h34, 8'h12, 8'h00, 8'hF0};

    dna_packetizer #(
        .SETTLE_CYCLES (SETTLE),
        .HEADER        (8'hD5)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .dna_data      (dna_data),
        .send          (send),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .dna_ready     (dna_ready),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Called with the packet's first byte already visible. bp selects the
    // 1,0,0,1 ready pattern; pulse_at >= 0 drives a one-cycle send at that
    // loop cycle and holds send low otherwise; -1 leaves send untouched.
    task automatic expect_packet(input string name, input bit bp, input int pulse_at);
        int         idx   = 0;
        int         cyc   = 0;
        bit         stall = 1'b0;
        logic [7:0] pd    = 8'h00;
        logic       pl    = 1'b0;
        while (idx < 10 && cyc < 100) begin
            m_axis_tready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (pulse_at >= 0) send = (cyc == pulse_at);
            tests++;
            if (m_axis_tvalid !== 1'b1) begin
                failed++;
                $display("FAIL %s tvalid byte %0d: got %b want 1", name, idx, m_axis_tvalid);
                break;
            end
            tests++;
            if (m_axis_tdata !== exp_pkt[idx] || m_axis_tlast !== (idx == 9) || busy !== 1'b1) begin
                failed++;
                $display("FAIL %s byte %0d: got data %h last %b busy %b want data %h last %b busy 1",
                         name, idx, m_axis_tdata, m_axis_tlast, busy, exp_pkt[idx], (idx == 9));
            end
            if (stall) begin
                tests++;
                if (m_axis_tdata !== pd || m_axis_tlast !== pl) begin
                    failed++;
                    $display("FAIL %s stall hold byte %0d: got %h/%b want %h/%b",
                             name, idx, m_axis_tdata, m_axis_tlast, pd, pl);
                end
            end
            stall = !m_axis_tready;
            pd    = m_axis_tdata;
            pl    = m_axis_tlast;
            if (m_axis_tready) idx++;
            tick();
            cyc++;
        end
        if (pulse_at >= 0) send = 1'b0;
        m_axis_tready = 1'b1;
        tests++;
        if (idx != 10 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL %s end: bytes %0d valid %b last %b busy %b want 10 0 0 0",
                     name, idx, m_axis_tvalid, m_axis_tlast, busy);
        end
    endtask

    // Starts just after reset release; returns just after edge SETTLE.
    task automatic wait_settle(input string name, input bit early);
        int rise_edge = 0;
        bit valid_seen = 1'b0;
        for (int e = 1; e <= SETTLE; e++) begin
            send = early && (e == 100 || e == 500 || e == 1000);
            tick();
            if (dna_ready === 1'b1 && rise_edge == 0) rise_edge = e;
            if (m_axis_tvalid !== 1'b0) valid_seen = 1'b1;
        end
        send = 1'b0;
        tests++;
        if (rise_edge != SETTLE) begin
            failed++;
            $display("FAIL %s dna_ready rise edge: got %0d want %0d", name, rise_edge, SETTLE);
        end
        tests++;
        if (valid_seen) begin
            failed++;
            $display("FAIL %s tvalid during settle: got 1 want 0", name);
        end
    endtask

    task automatic check_quiet(input string name, input int n);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            failed++;
            $display("FAIL %s extra packet: got tvalid/busy 1 want 0", name);
        end
    endtask

    task automatic check_reset_values(input string name);
        tests++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 8'h00 ||
            dna_ready !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL %s reset values: got valid %b last %b data %h ready %b busy %b want all 0",
                     name, m_axis_tvalid, m_axis_tlast, m_axis_tdata, dna_ready, busy);
        end
    endtask

    task automatic start_packet(input string name);
        send = 1'b1;
        tick();
        send = 1'b0;
        tests++;
        if (m_axis_tvalid !== 1'b1 || busy !== 1'b1 || m_axis_tdata !== 8'hD5) begin
            failed++;
            $display("FAIL %s start: got valid %b busy %b data %h want 1 1 d5",
                     name, m_axis_tvalid, busy, m_axis_tdata);
        end
    endtask

    task automatic test_reset();
        aresetn       = 1'b0;
        send          = 1'b0;
        m_axis_tready = 1'b1;
        dna_data      = 57'h0123456789ABCDE;
        tick();
        tick();
        check_reset_values("reset");
        aresetn = 1'b1;
    endtask

    task automatic test_settle();
        wait_settle("settle", 1'b0);
        tick();
        tests++;
        if (m_axis_tvalid !== 1'b0 || dna_ready !== 1'b1) begin
            failed++;
            $display("FAIL settle idle: got valid %b ready %b want 0 1", m_axis_tvalid, dna_ready);
        end
    endtask

    task automatic test_basic();
        start_packet("basic");
        expect_packet("basic", 1'b0, -1);
        check_quiet("basic", 5);
    endtask

    task automatic test_backpressure();
        start_packet("backpressure");
        expect_packet("backpressure", 1'b1, -1);
        check_quiet("backpressure", 5);
    endtask

    task automatic test_continuous();
        send = 1'b1;
        tick();
        expect_packet("cont_1", 1'b0, -1);
        tick();
        tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hD5) begin
            failed++;
            $display("FAIL cont gap: got valid %b data %h want 1 d5", m_axis_tvalid, m_axis_tdata);
        end
        expect_packet("cont_2", 1'b0, -1);
        send = 1'b0;
        check_quiet("cont_stop", 5);
        start_packet("send_in_send");
        expect_packet("send_in_send", 1'b0, 3);
        check_quiet("send_in_send", 10);
    endtask

    task automatic test_reset_mid_packet();
        start_packet("mid_reset");
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if (m_axis_tdata !== 8'h56) begin
            failed++;
            $display("FAIL mid_reset byte5: got %h want 56", m_axis_tdata);
        end
        aresetn = 1'b0;
        tick();
        check_reset_values("mid_reset");
        aresetn = 1'b1;
        wait_settle("mid_reset_resettle", 1'b0);
    endtask

    task automatic test_early_request();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        wait_settle("early", 1'b1);
        dna_data = {57{1'b1}};
        tick();
        tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hD5) begin
            failed++;
            $display("FAIL early start edge %0d: got valid %b data %h want 1 d5",
                     SETTLE + 1, m_axis_tvalid, m_axis_tdata);
        end
        expect_packet("early", 1'b0, -1);
        check_quiet("early_single", 20);
    endtask

    initial begin
        test_reset();
        test_settle();
        test_basic();
        test_backpressure();
        test_continuous();
        test_reset_mid_packet();
        test_early_request();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
